// File: rtl/adc_spi_capture.sv
// Serial-ADC capture front end: shared adc_clk/adc_cs, one data line per channel, valid/ready out.
// Define ADC_SIGNED_EN to convert each captured word from offset binary to two's complement.
module adc_spi_capture #(
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned LEAD_BITS  = 4,
  parameter int unsigned TRAIL_BITS = 0,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SAMPLE_DIV = 2500
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic                          adc_clk,
  output logic                          adc_cs,
  input  logic [CHANNELS-1:0]           adc_sd,
  output logic [CHANNELS*DATA_BITS-1:0] sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          overrun
);

  localparam int unsigned FRAME_BITS = LEAD_BITS + DATA_BITS + TRAIL_BITS;
  localparam int unsigned CntW       = $clog2(FRAME_BITS + 1);
  localparam int unsigned DivW       = $clog2(CLK_DIV + 1);
  localparam int unsigned TickW      = $clog2(SAMPLE_DIV + 1);

`ifdef ADC_SIGNED_EN
  localparam logic [DATA_BITS-1:0] SignFlip = DATA_BITS'(1) << (DATA_BITS - 1);
`else
  localparam logic [DATA_BITS-1:0] SignFlip = '0;
`endif
  localparam logic [CHANNELS*DATA_BITS-1:0] SignMask = {CHANNELS{SignFlip}};

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e                              state_q, state_d;
  logic [TickW-1:0]                    tick_cnt_q;
  logic [DivW-1:0]                     div_q;
  logic                                adc_clk_q;
  logic [CntW-1:0]                     bit_cnt_q;
  logic [CHANNELS-1:0][DATA_BITS-1:0]  shift_q;
  logic [CHANNELS*DATA_BITS-1:0]       sample_data_q;
  logic                                sample_valid_q;
  logic                                overrun_q;

  logic            tick;
  logic            half_end;
  logic            rise;
  logic            last_bit;
  logic            capture;
  logic            load;
  logic            xfer;
  logic [CntW-1:0] rel_bit;

  assign tick     = (tick_cnt_q == TickW'(SAMPLE_DIV - 1));
  assign half_end = (div_q == DivW'(CLK_DIV - 1));
  assign rise     = (state_q == StConvert) && half_end && !adc_clk_q;
  assign last_bit = (bit_cnt_q == CntW'(FRAME_BITS - 1));
  // Wraps for leading bits, so a single compare selects the data window.
  assign rel_bit  = bit_cnt_q - CntW'(LEAD_BITS);
  assign capture  = (rel_bit < CntW'(DATA_BITS));
  assign xfer     = sample_valid_q && sample_ready;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (tick && enable) state_d = StConvert;
      StConvert: if (rise && last_bit) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    adc_cs = 1'b1;
    load   = 1'b0;
    unique case (state_q)
      StConvert: adc_cs = 1'b0;
      StDone:    load   = 1'b1;
      default:   ;
    endcase
  end

  // Free-running sample-rate tick, independent of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  // Serial clock generation and per-channel shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      adc_clk_q <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state_q == StConvert) begin
      if (half_end) begin
        div_q     <= '0;
        adc_clk_q <= ~adc_clk_q;
      end else begin
        div_q <= div_q + DivW'(1);
      end
      if (rise) begin
        bit_cnt_q <= bit_cnt_q + CntW'(1);
        if (capture) begin
          for (int i = 0; i < int'(CHANNELS); i++) begin
            shift_q[i] <= (shift_q[i] << 1) | DATA_BITS'(adc_sd[i]);
          end
        end
      end
    end else begin
      div_q     <= '0;
      adc_clk_q <= 1'b1;
      bit_cnt_q <= '0;
    end
  end

  // Output register and handshake; a load always wins over a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else if (load) begin
      sample_data_q  <= shift_q ^ SignMask;
      sample_valid_q <= 1'b1;
      if (sample_valid_q && !sample_ready) overrun_q <= 1'b1;
    end else if (xfer) begin
      sample_valid_q <= 1'b0;
    end
  end

  assign adc_clk      = adc_clk_q;
  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture: two-channel ADC model, directed frames, queue-based checker.
module tb_adc_spi_capture;

  localparam int unsigned DataBits = 12;
  localparam int unsigned Chans    = 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        enable = 1'b0;
  logic                        adc_clk;
  logic                        adc_cs;
  logic [Chans-1:0]            adc_sd = '0;
  logic [Chans*DataBits-1:0]   sample_data;
  logic                        sample_valid;
  logic                        sample_ready = 1'b1;
  logic                        overrun;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_w;
  logic [15:0] fr0 = '0;
  logic [15:0] fr1 = '0;
  int          bit_idx = 0;

  adc_spi_capture #(
    .DATA_BITS (12),
    .LEAD_BITS (4),
    .TRAIL_BITS(0),
    .CHANNELS  (2),
    .CLK_DIV   (4),
    .SAMPLE_DIV(300)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .adc_clk     (adc_clk),
    .adc_cs      (adc_cs),
    .adc_sd      (adc_sd),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // ADC model: MSB-first frame, each bit driven on the falling edge of adc_clk.
  always @(negedge adc_cs) bit_idx = 0;
  always @(negedge adc_clk) begin
    if (adc_cs == 1'b0 && bit_idx < 16) begin
      adc_sd = {fr1[15-bit_idx], fr0[15-bit_idx]};
      bit_idx++;
    end
  end

  function automatic logic [11:0] cvt(input logic [11:0] d);
`ifdef ADC_SIGNED_EN
    return d ^ 12'h800;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_cs(input logic lvl, input string name);
    int n = 0;
    while (adc_cs !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (adc_cs !== lvl) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (sample_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sample_valid !== 1'b1) timeout(name);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 sample_ready = v;
  endtask

  task automatic load_frame(input logic [3:0] l0, input logic [11:0] d0,
                            input logic [3:0] l1, input logic [11:0] d1, input bit push);
    fr0 = {l0, d0};
    fr1 = {l1, d1};
    if (push) exp_q.push_back({cvt(d1), cvt(d0)});
  endtask

  // Monitor: pops one expected word per accepted transfer.
  always @(negedge clk) begin
    if (!reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got 0x%0h, expected no sample", sample_data);
      end else begin
        exp_w = exp_q.pop_front();
        check("sb_data", 32'(sample_data), 32'(exp_w));
      end
    end
  end

  initial begin
    int lat;
    int cs_n;
    int rises;
    int cnt;
    logic prev;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(adc_cs), 32'd1);
    check("rst_clk", 32'(adc_clk), 32'd1);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Basic frame with timing measurement.
    load_frame(4'h0, 12'hA5C, 4'h0, 12'h3C6, 1'b1);
    reset  = 1'b0;
    enable = 1'b1;
    wait_cs(1'b0, "t1_start");
    cs_n = 1; rises = 0; lat = 0; prev = adc_clk;
    while (sample_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (adc_cs == 1'b0) cs_n++;
      if (adc_clk && !prev) rises++;
      prev = adc_clk;
    end
    check("t1_latency", 32'(lat), 32'd129);
    check("t1_cs_low_cycles", 32'(cs_n), 32'd128);
    check("t1_clk_rises", 32'(rises), 32'd16);
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(sample_valid), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);

    // Two channels with nonzero leading bits on ch1 (discarded).
    load_frame(4'h0, 12'h123, 4'hA, 12'hFED, 1'b1);
    wait_cs(1'b0, "t2_start");
    wait_valid("t2_valid");

    // Overrun: first sample never accepted, second overwrites it.
    set_ready(1'b0);
    load_frame(4'h0, 12'h5A5, 4'h0, 12'h0F0, 1'b0);
    wait_cs(1'b0, "t3a_start");
    wait_valid("t3a_valid");
    check("t3a_data_held", 32'(sample_data), {8'h0, cvt(12'h0F0), cvt(12'h5A5)});
    check("t3a_overrun", 32'(overrun), 32'd0);
    load_frame(4'h0, 12'h9C3, 4'h0, 12'h3E1, 1'b1);
    wait_cs(1'b0, "t3b_start");
    wait_cs(1'b1, "t3b_end");
    @(negedge clk);
    check("t3b_valid", 32'(sample_valid), 32'd1);
    check("t3b_overrun", 32'(overrun), 32'd1);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("t3_valid_dropped", 32'(sample_valid), 32'd0);
    check("t3_overrun_sticky", 32'(overrun), 32'd1);

    // Enable dropped mid-frame: frame completes, no further frames.
    load_frame(4'h0, 12'h0F1, 4'h0, 12'hE2D, 1'b1);
    wait_cs(1'b0, "t4_start");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_valid("t4_valid");
    cnt = 0;
    repeat (920) begin
      @(negedge clk);
      if (adc_cs == 1'b0) cnt++;
    end
    check("t4_no_new_frames", 32'(cnt), 32'd0);

    // Reset mid-frame while a sample is held and overrun is set.
    set_ready(1'b0);
    enable = 1'b1;
    load_frame(4'h0, 12'h111, 4'h0, 12'h222, 1'b0);
    wait_cs(1'b0, "t5a_start");
    wait_valid("t5a_valid");
    load_frame(4'h0, 12'h333, 4'h0, 12'h444, 1'b0);
    wait_cs(1'b0, "t5b_start");
    repeat (44) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_cs", 32'(adc_cs), 32'd1);
    check("t5_rst_clk", 32'(adc_clk), 32'd1);
    check("t5_rst_valid", 32'(sample_valid), 32'd0);
    check("t5_rst_overrun", 32'(overrun), 32'd0);
    check("t5_rst_data", 32'(sample_data), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    set_ready(1'b1);
    load_frame(4'h0, 12'h7E4, 4'h0, 12'h18B, 1'b1);
    wait_cs(1'b0, "t5c_start");
    wait_valid("t5c_valid");
    @(negedge clk);
    check("t5c_overrun", 32'(overrun), 32'd0);

    // Offset-binary boundary codes.
    load_frame(4'h0, 12'h800, 4'h0, 12'hFFF, 1'b1);
    wait_cs(1'b0, "t6a_start");
    wait_valid("t6a_valid");
    load_frame(4'h0, 12'hFFF, 4'h0, 12'h800, 1'b1);
    wait_cs(1'b0, "t6b_start");
    wait_valid("t6b_valid");

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
